// File: rtl/sweep_controller_if.sv
// Control/feedback bundle between the sweep sequencer and its
// config layer plus counter datapath.
interface sweep_controller_if #(
    parameter int WIDTH   = 8,
    parameter int DWELL_W = 8,
    parameter int REPS_W  = 4
);
    logic               start;
    logic               abort;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   hi;
    logic [DWELL_W-1:0] dwell;
    logic [REPS_W-1:0]  reps;
    logic [WIDTH-1:0]   counter_in;
    logic               cnt_load;
    logic [WIDTH-1:0]   cnt_value;
    logic               cnt_dir;
    logic               cnt_pause;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output start, abort, lo, hi, dwell, reps, counter_in,
        input  cnt_load, cnt_value, cnt_dir, cnt_pause, busy, done, err
    );

    modport slave (
        input  start, abort, lo, hi, dwell, reps, counter_in,
        output cnt_load, cnt_value, cnt_dir, cnt_pause, busy, done, err
    );
endinterface

// File: rtl/sweep_controller.sv
// Triangle-sweep sequencer driving an up/down counter's load,
// direction and pause controls from captured lo/hi/dwell/reps.
module sweep_controller #(
    parameter int WIDTH   = 8,
    parameter int DWELL_W = 8,
    parameter int REPS_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    sweep_controller_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, LOAD, UP, DWELL_HI, DOWN, DWELL_LO, DONE
    } state_e;

    localparam logic [DWELL_W-1:0] D_ONE = DWELL_W'(1);
    localparam logic [REPS_W-1:0]  R_ONE = REPS_W'(1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [REPS_W-1:0]  reps_q, reps_d;
    logic [DWELL_W-1:0] dcnt_q, dcnt_d;
    logic [REPS_W-1:0]  rcnt_q, rcnt_d;
    logic               err_q, err_d;
    logic [REPS_W-1:0]  rcnt_inc;
    logic               load, dir, pause, done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            dwell_q <= '0;
            reps_q  <= '0;
            dcnt_q  <= '0;
            rcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            dwell_q <= dwell_d;
            reps_q  <= reps_d;
            dcnt_q  <= dcnt_d;
            rcnt_q  <= rcnt_d;
            err_q   <= err_d;
        end
    end

    assign rcnt_inc = rcnt_q + R_ONE;

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        dwell_d = dwell_q;
        reps_d  = reps_q;
        dcnt_d  = dcnt_q;
        rcnt_d  = rcnt_q;
        err_d   = 1'b0;
        load    = 1'b0;
        dir     = 1'b0;
        pause   = 1'b1;
        done    = 1'b0;
        // abort overrides every active state, including the done pulse
        if (state_q != IDLE && bus.abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        lo_d    = bus.lo;
                        hi_d    = bus.hi;
                        dwell_d = bus.dwell;
                        reps_d  = bus.reps;
                        if (bus.lo >= bus.hi || bus.reps == '0) begin
                            err_d = 1'b1;
                        end else begin
                            rcnt_d  = '0;
                            state_d = LOAD;
                        end
                    end
                end
                LOAD: begin
                    load    = 1'b1;
                    state_d = UP;
                end
                UP: begin
                    pause = 1'b0;
                    if (bus.counter_in == hi_q) begin
                        if (dwell_q == '0) begin
                            dir     = 1'b1;
                            state_d = DOWN;
                        end else begin
                            pause   = 1'b1;
                            dcnt_d  = dwell_q - D_ONE;
                            state_d = DWELL_HI;
                        end
                    end
                end
                DWELL_HI: begin
                    if (dcnt_q != '0) begin
                        dcnt_d = dcnt_q - D_ONE;
                    end else begin
                        dir     = 1'b1;
                        pause   = 1'b0;
                        state_d = DOWN;
                    end
                end
                DOWN: begin
                    dir   = 1'b1;
                    pause = 1'b0;
                    if (bus.counter_in == lo_q) begin
                        rcnt_d = rcnt_inc;
                        dir    = 1'b0;
                        if (rcnt_inc == reps_q) begin
                            pause   = 1'b1;
                            state_d = DONE;
                        end else if (dwell_q == '0) begin
                            state_d = UP;
                        end else begin
                            pause   = 1'b1;
                            dcnt_d  = dwell_q - D_ONE;
                            state_d = DWELL_LO;
                        end
                    end
                end
                DWELL_LO: begin
                    if (dcnt_q != '0) begin
                        dcnt_d = dcnt_q - D_ONE;
                    end else begin
                        pause   = 1'b0;
                        state_d = UP;
                    end
                end
                DONE: begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.cnt_load  = load;
    assign bus.cnt_value = lo_q;
    assign bus.cnt_dir   = dir;
    assign bus.cnt_pause = pause;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done;
    assign bus.err       = err_q;
endmodule
